// File: rtl/popcount_accum.sv
// popcount_accum
// Accumulates per-beat ones counts from an upstream popcount stage into a
// per-frame total and beat count, and presents one frame result at a time
// under a valid/ready handshake. While a result is held, upstream is stalled.
//
// Ports:
//   clk        - single clock, rising-edge active
//   rst        - asynchronous active-high reset
//   in_valid   - upstream beat valid
//   in_count   - ones count of the current beat (CNT_W bits)
//   in_last    - current beat closes its frame
//   in_ready   - block can accept a beat (NOT out_valid)
//   out_valid  - a frame result is held on the outputs
//   out_ready  - downstream accepts the result
//   out_total  - sum of in_count over the frame (TOTAL_W bits)
//   out_beats  - number of beats in the frame (BEAT_W bits)
//   out_sat    - total or beat count clamped during the frame
//
// Configuration macro: POPCOUNT_ACCUM_SAT_EN
//   defined   - sum and beat counters clamp at all-ones; out_sat reports it
//   undefined - sum and beat counters wrap; out_sat is tied to 0
module popcount_accum #(
    parameter int CNT_W   = 4,
    parameter int TOTAL_W = 12,
    parameter int BEAT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [CNT_W-1:0]   in_count,
    input  logic               in_last,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_total,
    output logic [BEAT_W-1:0]  out_beats,
    output logic               out_sat
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]         state;
    logic [TOTAL_W-1:0] sum;
    logic [BEAT_W-1:0]  beats;
    logic [TOTAL_W-1:0] sum_next;
    logic [BEAT_W-1:0]  beats_next;
    logic               accept;

`ifdef POPCOUNT_ACCUM_SAT_EN
    // Extra bit of headroom exposes the carry out so the add can clamp.
    function automatic logic [TOTAL_W:0] add_total(input logic [TOTAL_W-1:0] s,
                                                   input logic [CNT_W-1:0]   c);
        logic [TOTAL_W:0] w;
        w = {1'b0, s} + (TOTAL_W+1)'(c);
        return w;
    endfunction

    function automatic logic [BEAT_W:0] add_beat(input logic [BEAT_W-1:0] b);
        logic [BEAT_W:0] w;
        w = {1'b0, b} + (BEAT_W+1)'(1);
        return w;
    endfunction

    function automatic logic [TOTAL_W-1:0] sat_total(input logic [TOTAL_W:0] w);
        return w[TOTAL_W] ? {TOTAL_W{1'b1}} : w[TOTAL_W-1:0];
    endfunction

    function automatic logic [BEAT_W-1:0] sat_beat(input logic [BEAT_W:0] w);
        return w[BEAT_W] ? {BEAT_W{1'b1}} : w[BEAT_W-1:0];
    endfunction

    logic [TOTAL_W:0] sum_wide;
    logic [BEAT_W:0]  beats_wide;
    logic             ovf;
    logic             sat_acc;   // a clamp already happened earlier in this frame
    logic             sat_reg;

    always_comb begin
        sum_wide   = add_total(sum, in_count);
        beats_wide = add_beat(beats);
        sum_next   = sat_total(sum_wide);
        beats_next = sat_beat(beats_wide);
        ovf        = sum_wide[TOTAL_W] | beats_wide[BEAT_W];
    end

    assign out_sat = sat_reg;
`else
    // Plain modulo arithmetic: the carry out is simply dropped.
    function automatic logic [TOTAL_W-1:0] add_total(input logic [TOTAL_W-1:0] s,
                                                     input logic [CNT_W-1:0]   c);
        return s + TOTAL_W'(c);
    endfunction

    function automatic logic [BEAT_W-1:0] add_beat(input logic [BEAT_W-1:0] b);
        return b + BEAT_W'(1);
    endfunction

    always_comb begin
        sum_next   = add_total(sum, in_count);
        beats_next = add_beat(beats);
    end

    assign out_sat = 1'b0;
`endif

    assign out_valid = (state == HOLD);
    assign in_ready  = ~out_valid;
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            sum       <= '0;
            beats     <= '0;
            out_total <= '0;
            out_beats <= '0;
`ifdef POPCOUNT_ACCUM_SAT_EN
            sat_acc   <= 1'b0;
            sat_reg   <= 1'b0;
`endif
        end else begin
            // accept and the output handshake are mutually exclusive because
            // in_ready is low throughout HOLD.
            if (state == HOLD && out_ready) begin
                state <= ACCUM;
            end
            if (accept) begin
                if (in_last) begin
                    out_total <= sum_next;
                    out_beats <= beats_next;
                    sum       <= '0;
                    beats     <= '0;
                    state     <= HOLD;
`ifdef POPCOUNT_ACCUM_SAT_EN
                    sat_reg   <= sat_acc | ovf;
                    sat_acc   <= 1'b0;
`endif
                end else begin
                    sum       <= sum_next;
                    beats     <= beats_next;
`ifdef POPCOUNT_ACCUM_SAT_EN
                    sat_acc   <= sat_acc | ovf;
                    // The previous frame's flag is retired once a new frame starts.
                    sat_reg   <= 1'b0;
`endif
                end
            end
        end
    end

endmodule
